fft_bitreverse: RTL and testbench

//  Reorders a pipelined-FFT output stream from bit-reversed order into natural order.

---
 rtl/fft_bitreverse.sv | 65 ++++++
 tb/tb_fft_bitreverse.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fft_bitreverse.sv
`default_nettype none
// ==========================================================================
// fft_bitreverse : ping-pong buffer turning bit-reversed FFT output into natural order
// rev 1.0
// ==========================================================================
module fft_bitreverse #(
  parameter int LGSIZE = 12,
  parameter int WIDTH  = 26
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clk_enable,
  input  logic             i_sync,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sync
);

  localparam int N = 1 << LGSIZE;

  logic [LGSIZE:0]   waddr;
  logic              wait_for_sync;
  logic              primed;
  logic [LGSIZE-1:0] rev_addr;
  logic [LGSIZE:0]   raddr;
  logic              accept;
  logic              last_of_frame0;

  logic [WIDTH-1:0]  mem [0:2*N-1];

  for (genvar gi = 0; gi < LGSIZE; gi++) begin : g_rev
    assign rev_addr[gi] = waddr[LGSIZE-1-gi];
  end

  // The read bank is always the one not being written, so no collision handling.
  assign raddr          = {~waddr[LGSIZE], rev_addr};
  assign accept         = i_clk_enable && (!wait_for_sync || i_sync);
  assign last_of_frame0 = !waddr[LGSIZE] && (&waddr[LGSIZE-1:0]);

  always_ff @(posedge i_clk) begin
    if (!i_reset && accept)
      mem[waddr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      waddr         <= '0;
      wait_for_sync <= 1'b1;
      primed        <= 1'b0;
      o_data        <= '0;
      o_sync        <= 1'b0;
    end else if (i_clk_enable) begin
      if (accept) begin
        waddr         <= waddr + 1'b1;
        wait_for_sync <= 1'b0;
        if (last_of_frame0)
          primed <= 1'b1;
      end
      o_sync <= primed && (waddr[LGSIZE-1:0] == '0);
      o_data <= primed ? mem[raddr] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_bitreverse.sv
`default_nettype none
// Self-checking bench for fft_bitreverse: small (N=8) instance plus a full-size instance.
module tb_fft_bitreverse;

  localparam int N  = 8;
  localparam int NB = 4096;

  logic        clk;
  logic        rst, en, sync;
  logic [7:0]  data, odata;
  logic        osync;
  logic        rst2, en2, sync2;
  logic [25:0] data2, odata2;
  logic        osync2;

  int n_cmp = 0;
  int n_bad = 0;

  fft_bitreverse #(.LGSIZE(3), .WIDTH(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_clk_enable(en), .i_sync(sync),
    .i_data(data), .o_data(odata), .o_sync(osync)
  );

  fft_bitreverse #(.LGSIZE(12), .WIDTH(26)) dut_big (
    .i_clk(clk), .i_reset(rst2), .i_clk_enable(en2), .i_sync(sync2),
    .i_data(data2), .o_data(odata2), .o_sync(osync2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       in_sync;
    logic [7:0] in_data;
    logic       exp_sync;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [29];

  function automatic int brev(input int v, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++)
      if (v[i]) r |= (1 << (lg - 1 - i));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reset with enable low: reset must not depend on the strobe.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; sync = 1'b0; data = 8'hC3;
    @(posedge clk); #1;
    check("reset_data", {24'h0, odata}, 32'h0);
    check("reset_sync", {31'h0, osync}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Frames of 16*f + n + base, sync at each frame start; disabled cycles drive junk.
  task automatic stream(input int nframes, input int base, input int gap_pct, input int abort_at);
    logic [7:0] samp [$];
    int k = 0;
    int m;
    logic [7:0] pd = 8'h00;
    logic       ps = 1'b0;
    bit e;
    while (k < nframes * N && k != abort_at) begin
      e = ($urandom_range(99) >= gap_pct);
      @(negedge clk);
      en = e;
      if (e) begin
        sync = (k % N == 0);
        data = 8'(base + 16 * (k / N) + k % N);
      end else begin
        sync = 1'b1;
        data = 8'hEE;
      end
      @(posedge clk); #1;
      if (e) begin
        samp.push_back(data);
        if (k < N) begin
          pd = 8'h00; ps = 1'b0;
        end else begin
          m  = k - N;
          pd = samp[(m / N) * N + brev(m % N, 3)];
          ps = (m % N == 0);
        end
        k++;
      end
      check("stream_data", {24'h0, odata}, {24'h0, pd});
      check("stream_sync", {31'h0, osync}, {31'h0, ps});
    end
  endtask

  task automatic big_stream();
    int m;
    logic [25:0] ed;
    logic        es;
    @(negedge clk);
    rst2 = 1'b1; en2 = 1'b0;
    @(posedge clk); #1;
    check("big_reset", {5'h0, osync2, odata2}, 32'h0);
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 0; k < 3 * NB; k++) begin
      @(negedge clk);
      en2 = 1'b1; sync2 = (k % NB == 0); data2 = 26'(k);
      @(posedge clk); #1;
      if (k < NB) begin
        ed = '0; es = 1'b0;
      end else begin
        m  = k - NB;
        ed = 26'((m / NB) * NB + brev(m % NB, 12));
        es = (m % NB == 0);
      end
      check("big_data", {6'h0, odata2}, {6'h0, ed});
      check("big_sync", {31'h0, osync2}, {31'h0, es});
    end
    @(negedge clk);
    en2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; data = '0;
    rst2 = 1'b1; en2 = 1'b0; sync2 = 1'b0; data2 = '0;

    // Pre-sync garbage, locked frame, stray sync at index 3, continuous follow-on.
    tbl = '{
      '{1'b0, 8'hA0, 1'b0, 8'h00}, '{1'b0, 8'hA1, 1'b0, 8'h00},
      '{1'b0, 8'hA2, 1'b0, 8'h00}, '{1'b0, 8'hA3, 1'b0, 8'h00},
      '{1'b0, 8'hA4, 1'b0, 8'h00},
      '{1'b1, 8'h00, 1'b0, 8'h00}, '{1'b0, 8'h01, 1'b0, 8'h00},
      '{1'b0, 8'h02, 1'b0, 8'h00}, '{1'b1, 8'h03, 1'b0, 8'h00},
      '{1'b0, 8'h04, 1'b0, 8'h00}, '{1'b0, 8'h05, 1'b0, 8'h00},
      '{1'b0, 8'h06, 1'b0, 8'h00}, '{1'b0, 8'h07, 1'b0, 8'h00},
      '{1'b0, 8'h08, 1'b1, 8'h00}, '{1'b0, 8'h09, 1'b0, 8'h04},
      '{1'b0, 8'h0A, 1'b0, 8'h02}, '{1'b0, 8'h0B, 1'b0, 8'h06},
      '{1'b0, 8'h0C, 1'b0, 8'h01}, '{1'b0, 8'h0D, 1'b0, 8'h05},
      '{1'b0, 8'h0E, 1'b0, 8'h03}, '{1'b0, 8'h0F, 1'b0, 8'h07},
      '{1'b1, 8'h10, 1'b1, 8'h08}, '{1'b0, 8'h11, 1'b0, 8'h0C},
      '{1'b0, 8'h12, 1'b0, 8'h0A}, '{1'b0, 8'h13, 1'b0, 8'h0E},
      '{1'b0, 8'h14, 1'b0, 8'h09}, '{1'b0, 8'h15, 1'b0, 8'h0D},
      '{1'b0, 8'h16, 1'b0, 8'h0B}, '{1'b0, 8'h17, 1'b0, 8'h0F}
    };

    do_reset();
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      en = 1'b1; sync = tbl[i].in_sync; data = tbl[i].in_data;
      @(posedge clk); #1;
      check("tbl_data", {24'h0, odata}, {24'h0, tbl[i].exp_data});
      check("tbl_sync", {31'h0, osync}, {31'h0, tbl[i].exp_sync});
    end

    // Steady state: 5 input frames give 4 checked output frames.
    do_reset();
    stream(5, 0, 0, -1);

    // Clock-enable gaps around 50%.
    do_reset();
    stream(3, 0, 50, -1);

    // Reset at output index 4 of frame 1, with sync high on the reset cycle.
    do_reset();
    stream(3, 8'h80, 0, 2 * N + 4);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; sync = 1'b1; data = 8'h55;
    @(posedge clk); #1;
    check("midrst_data", {24'h0, odata}, 32'h0);
    check("midrst_sync", {31'h0, osync}, 32'h0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    stream(3, 8'h20, 25, -1);

    big_stream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
